wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles a granted strobe may wait for ACK before a forced completion (8..1023).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port m0, WB4.slave, 32-bit bus: requester 0 (CPU data port); uses ADR, DAT_O, DAT_I, WE, CYC, STB, ACK.
REQ-005 SHALL have port m1, WB4.slave, 32-bit bus: requester 1 (DMA/debug master); same signals.
REQ-006 SHALL have port bus, WB4.master, 32-bit bus: shared downstream port that feeds the address decoder.
REQ-007 SHALL have port gnt, output, 2: one-hot current owner; 2'b00 when idle.
REQ-008 SHALL have port timeout_o, output, 1: one-cycle pulse on a forced completion.

Function
REQ-009 SHALL implement FSM states IDLE, GNT0 and GNT1, held in a registered state.
REQ-010 IDLE: if exactly one of m0.CYC or m1.CYC is high, SHALL go to that master's GNT state next cycle.
REQ-011 IDLE, both CYC high: SHALL grant the master that was not granted last (round-robin); the last-granted register SHALL update on every grant.
REQ-012 GNTx SHALL hold while mx.CYC is high; no preemption.
REQ-013 GNTx with mx.CYC low: SHALL go directly to the other GNT state if the other master's CYC is high, else to IDLE.
REQ-014 Arbitration latency SHALL be exactly 1 cycle: request at edge N gives grant and bus drive from cycle N+1.
REQ-015 In GNTx, bus ADR/DAT_O/WE/CYC/STB SHALL equal mx's signals combinationally, and mx.ACK/DAT_I SHALL equal bus.ACK/DAT_I.
REQ-016 In IDLE, bus CYC/STB/WE SHALL be 0 and ADR/DAT_O 0.
REQ-017 A master without grant SHALL see ACK=0 and DAT_I=0.
REQ-018 gnt SHALL be a decode of the registered state: GNT0 gives 01, GNT1 gives 10.
REQ-019 A wait counter (10 bits) SHALL increment each granted cycle with bus.STB=1 and bus.ACK=0, and SHALL clear on ACK, on a grant change, or in IDLE.
REQ-020 Counter saturation is prevented by REQ-023; wrap-around SHALL never occur.

Reset
REQ-021 rst low SHALL asynchronously force state=IDLE, last-granted=m1 (so m0 wins the first tie), counter=0, timeout_o=0 and gnt=00; all bus outputs 0.
REQ-022 Reset asserted mid-transfer SHALL drop bus.CYC/STB immediately; no ACK SHALL be delivered to either master.

Configuration
REQ-023 With macro WB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1 and ACK is still low, the owner SHALL, for one cycle, receive ACK=1 and DAT_I=32'hDEADBEEF; bus.STB SHALL be forced 0; timeout_o SHALL pulse 1; and the counter SHALL clear.
REQ-024 Without WB_ARB_TIMEOUT_EN, the counter, forced ACK and timeout_o logic SHALL be absent; timeout_o SHALL be tied 0, and a stalled slave holds the grant indefinitely.

Structure
REQ-025 Shared package wb_pkg SHALL hold: typedef arb_state_t {IDLE, GNT0, GNT1}, constant WB_TIMEOUT_DATA = 32'hDEADBEEF, and constant WB_ADDR_W = 32.
REQ-026 The round-robin pick SHALL be a sub-module rr_pick2 (inputs req[1:0], last; output sel), purely combinational; FSM and counter stay in wb_arbiter.

Verification
REQ-027 Only m0 raises CYC/STB, reading ADR 32'h00000010 with the slave ACKing after 2 cycles -> gnt=01 one cycle later, m0.DAT_I = slave data, m1.ACK=0 throughout.
REQ-028 m0 and m1 raise CYC on the same edge after reset -> GNT0 first; when m0 drops CYC, GNT1 on the next cycle with no IDLE gap; next simultaneous request goes to m0.
REQ-029 m1 granted, m0 requests mid-transfer -> m1 keeps grant until its CYC falls; m0 ACK stays 0.
REQ-030 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ACKs -> 16th waiting cycle: m0.ACK=1, m0.DAT_I=32'hDEADBEEF, timeout_o=1 for one cycle, bus.STB=0.
REQ-031 rst pulsed low while GNT0 is waiting for ACK -> bus.CYC=0 and gnt=00 in the same cycle; after release, IDLE, and a late slave ACK is not forwarded.
REQ-032 Macro undefined, slave stalls for 1000 cycles -> no forced ACK, timeout_o=0, grant held.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_pkg;
  localparam int unsigned WB_ADDR_W       = 32;
  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/wb4_if.sv
// Wishbone B4 classic bus bundle; master drives ADR/DAT_O/WE/CYC/STB, slave returns DAT_I/ACK.
interface wb4_if;
  import wb_pkg::*;

  logic [WB_ADDR_W-1:0] adr;
  logic [31:0]          dat_o;
  logic [31:0]          dat_i;
  logic                 we;
  logic                 cyc;
  logic                 stb;
  logic                 ack;

  modport master (output adr, dat_o, we, cyc, stb, input dat_i, ack);
  modport slave  (input adr, dat_o, we, cyc, stb, output dat_i, ack);
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the master not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);
  always_comb begin
    sel = 1'b0;
    case (req)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last;
      default: sel = 1'b0;
    endcase
  end
endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter, round-robin on ties, no preemption.
// Optional ACK watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  wb4_if.slave       m0,
  wb4_if.slave       m1,
  wb4_if.master      bus,
  output logic [1:0] gnt,
  output logic       timeout_o
);

  if (TIMEOUT_CYCLES < 8 || TIMEOUT_CYCLES > 1023) begin : g_bad_cfg
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 8..1023");
  end

  arb_state_t r_state;
  arb_state_t w_nxt;
  logic       r_last;
  logic [1:0] w_req;
  logic       w_sel;
  logic       w_stb_own;
  logic       w_force;

  assign w_req = {m1.cyc, m0.cyc};

  rr_pick2 u_pick (
    .req  (w_req),
    .last (r_last),
    .sel  (w_sel)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_nxt = w_sel ? GNT1 : GNT0;
      GNT0:    if (!m0.cyc) w_nxt = m1.cyc ? GNT1 : IDLE;
      GNT1:    if (!m1.cyc) w_nxt = m0.cyc ? GNT0 : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // r_last: 0 = m0 granted last, 1 = m1; reset to m1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state && w_nxt != IDLE) r_last <= (w_nxt == GNT1);
    end
  end

  assign gnt       = {r_state == GNT1, r_state == GNT0};
  assign w_stb_own = ((r_state == GNT0) && m0.stb) || ((r_state == GNT1) && m1.stb);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [9:0] LP_LIMIT = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] r_wait;

  assign w_force = w_stb_own && !bus.ack && (r_wait == LP_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
    end else if (w_nxt != r_state || r_state == IDLE || bus.ack || w_force) begin
      r_wait <= '0;
    end else if (w_stb_own) begin
      r_wait <= r_wait + 10'd1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign timeout_o = w_force;

  // Forced completion hides STB from the slave and answers the owner locally
  always_comb begin
    bus.adr   = '0;
    bus.dat_o = '0;
    bus.we    = 1'b0;
    bus.cyc   = 1'b0;
    bus.stb   = 1'b0;
    m0.ack    = 1'b0;
    m0.dat_i  = '0;
    m1.ack    = 1'b0;
    m1.dat_i  = '0;
    case (r_state)
      GNT0: begin
        bus.adr   = m0.adr;
        bus.dat_o = m0.dat_o;
        bus.we    = m0.we;
        bus.cyc   = m0.cyc;
        bus.stb   = m0.stb & ~w_force;
        m0.ack    = bus.ack | w_force;
        m0.dat_i  = w_force ? WB_TIMEOUT_DATA : bus.dat_i;
      end
      GNT1: begin
        bus.adr   = m1.adr;
        bus.dat_o = m1.dat_o;
        bus.we    = m1.we;
        bus.cyc   = m1.cyc;
        bus.stb   = m1.stb & ~w_force;
        m1.ack    = bus.ack | w_force;
        m1.dat_i  = w_force ? WB_TIMEOUT_DATA : bus.dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus reset and watchdog/stall sequences.
// Exercises the timeout path when WB_ARB_TIMEOUT_EN is defined, the stall path otherwise.
module tb_wb_arbiter;
  localparam logic [31:0] M0_DO = 32'h1111_0000;
  localparam logic [31:0] M1_DO = 32'h2222_0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gnt;
  logic       timeout_o;
  int         n_tests = 0;
  int         n_fail  = 0;

  wb4_if m0_if ();
  wb4_if m1_if ();
  wb4_if bus_if ();

  wb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .bus       (bus_if),
    .gnt       (gnt),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        c0;
    logic [31:0] a0;
    logic        c1;
    logic [31:0] a1;
    logic        ack;
    logic [31:0] sd;
    logic [1:0]  g;
    logic        bc;
    logic [31:0] ba;
    logic        k0;
    logic [31:0] d0;
    logic        k1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(string n, logic c0, logic [31:0] a0, logic c1, logic [31:0] a1,
                              logic ack, logic [31:0] sd, logic [1:0] g, logic bc,
                              logic [31:0] ba, logic k0, logic [31:0] d0, logic k1,
                              logic [31:0] d1);
    vec_t v;
    v.name = n; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1; v.ack = ack; v.sd = sd;
    v.g = g; v.bc = bc; v.ba = ba; v.k0 = k0; v.d0 = d0; v.k1 = k1; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c0, input logic [31:0] a0, input logic c1,
                       input logic [31:0] a1, input logic ack, input logic [31:0] sd);
    m0_if.cyc = c0; m0_if.stb = c0; m0_if.adr = a0; m0_if.we = 1'b0; m0_if.dat_o = M0_DO;
    m1_if.cyc = c1; m1_if.stb = c1; m1_if.adr = a1; m1_if.we = c1;   m1_if.dat_o = M1_DO;
    bus_if.ack = ack; bus_if.dat_i = sd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] exp_do;
    logic        exp_we;
    logic        bad;

    vecs[0]  = mk("rst",        0, 0,     0, 0,     0, 0,            2'b00, 0, 0,     0, 0,            0, 0);
    vecs[1]  = mk("tie_req",    1, 32'h20, 1, 32'h30, 0, 0,          2'b00, 0, 0,     0, 0,            0, 0);
    vecs[2]  = mk("tie_g0",     1, 32'h20, 1, 32'h30, 0, 0,          2'b01, 1, 32'h20, 0, 0,           0, 0);
    vecs[3]  = mk("g0_ack",     1, 32'h20, 1, 32'h30, 1, 32'hA5A50000, 2'b01, 1, 32'h20, 1, 32'hA5A50000, 0, 0);
    vecs[4]  = mk("g0_drop",    0, 0,     1, 32'h30, 0, 0,           2'b01, 0, 0,     0, 0,            0, 0);
    vecs[5]  = mk("g1_handoff", 0, 0,     1, 32'h30, 1, 32'h5A5A0000, 2'b10, 1, 32'h30, 0, 0,           1, 32'h5A5A0000);
    vecs[6]  = mk("g1_drop",    0, 0,     0, 0,     0, 0,            2'b10, 0, 0,     0, 0,            0, 0);
    vecs[7]  = mk("tie2_req",   1, 32'h40, 1, 32'h50, 0, 0,          2'b00, 0, 0,     0, 0,            0, 0);
    vecs[8]  = mk("tie2_g0",    1, 32'h40, 1, 32'h50, 0, 0,          2'b01, 1, 32'h40, 0, 0,           0, 0);
    vecs[9]  = mk("tie2_ack",   1, 32'h40, 1, 32'h50, 1, 32'h1,      2'b01, 1, 32'h40, 1, 32'h1,       0, 0);
    vecs[10] = mk("m0_rel",     0, 0,     1, 32'h50, 0, 0,           2'b01, 0, 0,     0, 0,            0, 0);
    vecs[11] = mk("g1_hold",    1, 32'h60, 1, 32'h50, 0, 0,          2'b10, 1, 32'h50, 0, 0,           0, 0);
    vecs[12] = mk("g1_ack",     1, 32'h60, 1, 32'h50, 1, 32'h77,     2'b10, 1, 32'h50, 0, 0,           1, 32'h77);
    vecs[13] = mk("g1_hold2",   1, 32'h60, 1, 32'h50, 0, 0,          2'b10, 1, 32'h50, 0, 0,           0, 0);
    vecs[14] = mk("g1_rel",     1, 32'h60, 0, 0,     0, 0,           2'b10, 0, 0,     0, 0,            0, 0);
    vecs[15] = mk("g0_ack2",    1, 32'h60, 0, 0,     1, 32'h88,      2'b01, 1, 32'h60, 1, 32'h88,      0, 0);
    vecs[16] = mk("g0_rel",     0, 0,     0, 0,     0, 0,            2'b01, 0, 0,     0, 0,            0, 0);
    vecs[17] = mk("idle",       0, 0,     0, 0,     0, 0,            2'b00, 0, 0,     0, 0,            0, 0);
    vecs[18] = mk("m0_req",     1, 32'h10, 0, 0,    0, 0,            2'b00, 0, 0,     0, 0,            0, 0);
    vecs[19] = mk("m0_wait1",   1, 32'h10, 0, 0,    0, 0,            2'b01, 1, 32'h10, 0, 0,           0, 0);
    vecs[20] = mk("m0_wait2",   1, 32'h10, 0, 0,    0, 0,            2'b01, 1, 32'h10, 0, 0,           0, 0);
    vecs[21] = mk("m0_ack",     1, 32'h10, 0, 0,    1, 32'hCAFE0001, 2'b01, 1, 32'h10, 1, 32'hCAFE0001, 0, 0);
    vecs[22] = mk("m0_done",    0, 0,     0, 0,     0, 0,            2'b01, 0, 0,     0, 0,            0, 0);
    vecs[23] = mk("idle2",      0, 0,     0, 0,     0, 0,            2'b00, 0, 0,     0, 0,            0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].c0, vecs[i].a0, vecs[i].c1, vecs[i].a1, vecs[i].ack, vecs[i].sd);
      #2;
      exp_do = (vecs[i].g == 2'b01) ? M0_DO : (vecs[i].g == 2'b10) ? M1_DO : 32'h0;
      exp_we = (vecs[i].g == 2'b10) && vecs[i].c1;
      chk({vecs[i].name, ".gnt"}, 32'(gnt), 32'(vecs[i].g));
      chk({vecs[i].name, ".cyc_stb_we"}, {29'b0, bus_if.cyc, bus_if.stb, bus_if.we},
          {29'b0, vecs[i].bc, vecs[i].bc, exp_we});
      chk({vecs[i].name, ".adr"}, bus_if.adr, vecs[i].ba);
      chk({vecs[i].name, ".dat_o"}, bus_if.dat_o, exp_do);
      chk({vecs[i].name, ".ack0_ack1_to"}, {29'b0, m0_if.ack, m1_if.ack, timeout_o},
          {29'b0, vecs[i].k0, vecs[i].k1, 1'b0});
      chk({vecs[i].name, ".m0_dat_i"}, m0_if.dat_i, vecs[i].d0);
      chk({vecs[i].name, ".m1_dat_i"}, m1_if.dat_i, vecs[i].d1);
      tick();
    end

    // Reset pulse while GNT0 waits for ACK; a late ACK must not leak through
    drive(1, 32'h70, 0, 0, 0, 0);
    tick();
    #2;
    chk("rstmid.pre_gnt", 32'(gnt), 32'h1);
    chk("rstmid.pre_cyc", 32'(bus_if.cyc), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.cyc_stb", {30'b0, bus_if.cyc, bus_if.stb}, 32'h0);
    chk("rstmid.gnt", 32'(gnt), 32'h0);
    drive(0, 0, 0, 0, 1, 32'h1234);
    #1;
    chk("rstmid.late_ack", {30'b0, m0_if.ack, m1_if.ack}, 32'h0);
    chk("rstmid.late_dat", m0_if.dat_i, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    chk("rstpost.gnt", 32'(gnt), 32'h0);
    chk("rstpost.ack", {30'b0, m0_if.ack, m1_if.ack}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    drive(1, 32'h80, 0, 0, 0, 0);
    tick();
    bad = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      #2;
      if (m0_if.ack !== 1'b0 || timeout_o !== 1'b0 || bus_if.stb !== 1'b1) bad = 1'b1;
      tick();
    end
    chk("to.wait15_quiet", 32'(bad), 32'h0);
    #2;
    chk("to.ack", 32'(m0_if.ack), 32'h1);
    chk("to.dat", m0_if.dat_i, 32'hDEADBEEF);
    chk("to.pulse", 32'(timeout_o), 32'h1);
    chk("to.stb_cyc", {30'b0, bus_if.stb, bus_if.cyc}, 32'h1);
    chk("to.gnt", 32'(gnt), 32'h1);
    tick();
    #2;
    chk("to.after", {29'b0, m0_if.ack, timeout_o, bus_if.stb}, 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
`else
    drive(1, 32'h80, 0, 0, 0, 0);
    tick();
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      #2;
      if (m0_if.ack !== 1'b0 || timeout_o !== 1'b0 || gnt !== 2'b01 || bus_if.stb !== 1'b1)
        bad = 1'b1;
      tick();
    end
    chk("stall.1000_quiet", 32'(bad), 32'h0);
    #2;
    chk("stall.gnt_held", 32'(gnt), 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
